// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the Avalon-MM PIO slaves: register offsets and pulse engine states.
package soc_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_OUT    = 3'd2;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
    localparam logic [2:0] ADDR_PULSE  = 3'd6;
    localparam logic [2:0] ADDR_PLEN   = 3'd7;

    typedef enum logic {
        PULSE_IDLE,
        PULSE_ACTIVE
    } pulse_state_e;

endpackage

// File: rtl/soc_system_led_pio_pulse_timer.sv
// Retriggerable one-shot: forces mask bits high for plen clocks after a valid trigger.
module soc_system_led_pio_pulse_timer
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned PULSE_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trigger_i,
    input  logic [WIDTH-1:0]   mask_in_i,
    input  logic [PULSE_W-1:0] plen_i,
    output logic [WIDTH-1:0]   pulse_mask_o
);

    pulse_state_e       state_q;
    logic [PULSE_W-1:0] cnt_q;
    logic [WIDTH-1:0]   mask_q;
    logic               valid;

    // Zero length or empty mask triggers are dropped entirely.
    assign valid = trigger_i && (plen_i != '0) && (mask_in_i != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PULSE_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            case (state_q)
                PULSE_IDLE: begin
                    if (valid) begin
                        state_q <= PULSE_ACTIVE;
                        cnt_q   <= plen_i;
                        mask_q  <= mask_in_i;
                    end
                end
                PULSE_ACTIVE: begin
                    // Retrigger wins over expiry so already-lit bits are extended.
                    if (valid) begin
                        cnt_q  <= plen_i;
                        mask_q <= mask_q | mask_in_i;
                    end else if (cnt_q == PULSE_W'(1)) begin
                        state_q <= PULSE_IDLE;
                        cnt_q   <= '0;
                        mask_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q - PULSE_W'(1);
                    end
                end
                default: begin
                    state_q <= PULSE_IDLE;
                    cnt_q   <= '0;
                    mask_q  <= '0;
                end
            endcase
        end
    end

    assign pulse_mask_o = mask_q;

endmodule

// File: rtl/soc_system_led_pio.sv
// LED output PIO: data register with set/clear aliases, pulse engine, registered read path.
module soc_system_led_pio
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned     WIDTH         = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int unsigned     PULSE_W       = 16,
    parameter int unsigned     PULSE_DEFAULT = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic               wr;
    logic [WIDTH-1:0]   wd;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [PULSE_W-1:0] plen_q, plen_d;
    logic [31:0]        readdata_q, readdata_d;
    logic [WIDTH-1:0]   pulse_mask;
    logic               unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d = data_q;
        plen_d = plen_q;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_d = wd;
                ADDR_OUTSET: data_d = data_q | wd;
                ADDR_OUTCLR: data_d = data_q & ~wd;
                ADDR_PLEN:   plen_d = writedata[PULSE_W-1:0];
                default:     ;
            endcase
        end
    end

    // Read mux sees pre-write register values, so same-cycle read returns old data.
    always_comb begin
        case (address)
            ADDR_DATA:  readdata_d = 32'(data_q);
            ADDR_OUT:   readdata_d = 32'(out_port);
            ADDR_PULSE: readdata_d = 32'(pulse_mask);
            ADDR_PLEN:  readdata_d = 32'(plen_q);
            default:    readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            plen_q     <= PULSE_W'(PULSE_DEFAULT);
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            plen_q     <= plen_d;
            readdata_q <= readdata_d;
        end
    end

    soc_system_led_pio_pulse_timer #(
        .WIDTH   (WIDTH),
        .PULSE_W (PULSE_W)
    ) u_pulse_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .trigger_i    (wr && (address == ADDR_PULSE)),
        .mask_in_i    (wd),
        .plen_i       (plen_q),
        .pulse_mask_o (pulse_mask)
    );

    assign out_port = data_q | pulse_mask;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_soc_system_led_pio.sv
// Directed bench for soc_system_led_pio with WIDTH=4, RESET_VALUE=4'b0101.
module tb_soc_system_led_pio;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int checks = 0;
    int errors = 0;

    soc_system_led_pio #(
        .WIDTH         (4),
        .RESET_VALUE   (4'b0101),
        .PULSE_W       (16),
        .PULSE_DEFAULT (1000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle write; returns 1ns after the edge that commits it.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // 1: reset values
        tick();
        tick();
        chk("rst_out", 32'(out_port), 32'h5);
        chk("rst_rdata", readdata, 32'h0);
        #3 reset_n = 1'b1;
        tick();
        chk("rel_out", 32'(out_port), 32'h5);
        rd(3'd7);
        chk("plen_default", readdata, 32'd1000);

        // 2: DATA / OUTSET / OUTCLR
        wr(3'd0, 32'h3);
        chk("data_wr", 32'(out_port), 32'h3);
        wr(3'd4, 32'hFFFF_FFF8);
        chk("outset", 32'(out_port), 32'hB);
        wr(3'd5, 32'h1);
        chk("outclr", 32'(out_port), 32'hA);
        rd(3'd0);
        chk("rd_data", readdata, 32'hA);
        rd(3'd2);
        chk("rd_out", readdata, 32'hA);
        rd(3'd4);
        chk("rd_outset0", readdata, 32'h0);
        wr(3'd1, 32'hF);
        chk("wr_hole", 32'(out_port), 32'hA);
        rd(3'd1);
        chk("rd_hole", readdata, 32'h0);

        // same-cycle read/write of DATA returns the old value
        wr(3'd0, 32'h0);
        chk("rd_old", readdata, 32'hA);

        // 3: single pulse of 5 clocks
        wr(3'd7, 32'h5);
        rd(3'd7);
        chk("plen5", readdata, 32'h5);
        wr(3'd6, 32'h4);
        chk("p3_c0", 32'(out_port), 32'h4);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("p3_c%0d", i), 32'(out_port), 32'h4);
            chk($sformatf("p3_rd%0d", i), readdata, 32'h4);
        end
        tick();
        chk("p3_end", 32'(out_port), 32'h0);
        tick();
        chk("p3_rd_end", readdata, 32'h0);

        // 4: retrigger three clocks later extends bit0
        wr(3'd6, 32'h1);
        chk("p4_a0", 32'(out_port), 32'h1);
        tick();
        chk("p4_a1", 32'(out_port), 32'h1);
        tick();
        chk("p4_a2", 32'(out_port), 32'h1);
        wr(3'd6, 32'h2);
        chk("p4_b0", 32'(out_port), 32'h3);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("p4_b%0d", i), 32'(out_port), 32'h3);
        end
        tick();
        chk("p4_end", 32'(out_port), 32'h0);

        // 5: invalid pulse writes
        wr(3'd7, 32'h0);
        wr(3'd6, 32'hF);
        chk("p5_plen0", 32'(out_port), 32'h0);
        rd(3'd6);
        tick();
        chk("p5_mask0", readdata, 32'h0);
        wr(3'd7, 32'h5);
        wr(3'd6, 32'h0);
        chk("p5_wd0", 32'(out_port), 32'h0);
        tick();
        tick();
        chk("p5_wd0_rd", readdata, 32'h0);

        // 6: asynchronous reset mid-pulse
        wr(3'd0, 32'h6);
        wr(3'd6, 32'h1);
        tick();
        tick();
        chk("p6_pre", 32'(out_port), 32'h7);
        #2 reset_n = 1'b0;
        #1;
        chk("p6_async_out", 32'(out_port), 32'h5);
        chk("p6_async_rd", readdata, 32'h0);
        tick();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("p6_no_residual", 32'(out_port), 32'h5);
        rd(3'd7);
        chk("p6_plen", readdata, 32'd1000);
        rd(3'd6);
        chk("p6_mask", readdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soc_system_led_pio.md
Name: soc_system_led_pio

Overview:
Avalon-MM slave output PIO. It is the write-direction counterpart of the switch input PIO and drives the board LEDs from the HPS/Nios lightweight bus. It holds a software-written data register with atomic set and clear aliases. A retriggerable one-shot pulse engine forces selected bits high for a programmable number of clocks, so firmware can flash LEDs without polling.

Parameters:
WIDTH, 4, number of output bits (1..32).
RESET_VALUE, 0, value of the data register after reset (WIDTH bits).
PULSE_W, 16, width of the pulse-length register and down-counter (1..32).
PULSE_DEFAULT, 1000, pulse length after reset, in clk cycles.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset_n  input  1  reset, asynchronous and active-low.
address  input  3  word address within the slave.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe; qualified by chipselect.
writedata  input  32  write data; bits above WIDTH/PULSE_W are ignored.
readdata  output  32  registered read data, zero-extended.
out_port  output  WIDTH  LED drive = data_reg | pulse_mask.

Behaviour:
- Register map (word offsets):
  - 0 DATA, R/W.
  - 2 OUT, R: current out_port.
  - 4 OUTSET, W.
  - 5 OUTCLR, W.
  - 6 PULSE, W; reads the active pulse_mask.
  - 7 PLEN, R/W.
  - 1 and 3 read 0 and ignore writes. OUTSET and OUTCLR also read 0.
- Write strobe: wr = chipselect & ~write_n. Every write takes effect at the clock edge where wr is sampled high. There are no wait states.
- DATA write: data_reg <= writedata[WIDTH-1:0].
- OUTSET: data_reg <= data_reg | wd. OUTCLR: data_reg <= data_reg & ~wd.
- PLEN write: plen <= writedata[PULSE_W-1:0]. Affects later triggers only; an active pulse keeps its count.
- Pulse engine:
  - States IDLE and ACTIVE. Counter cnt is PULSE_W bits; pulse_mask is WIDTH bits.
  - IDLE + PULSE write with plen != 0 and wd != 0: go to ACTIVE; cnt <= plen; pulse_mask <= wd.
  - PULSE write with plen == 0 or wd == 0: ignored.
  - ACTIVE: cnt decrements by 1 per clock. When cnt == 1: go to IDLE, pulse_mask <= 0, cnt <= 0.
  - Bits are therefore forced high for exactly plen cycles, counted from the edge after the write.
  - ACTIVE + valid PULSE write (retrigger): pulse_mask <= pulse_mask | wd; cnt <= plen. This takes priority over expiry in the same cycle, so old bits are extended, not dropped.
- out_port is combinational from registers (data_reg | pulse_mask) and changes in the cycle after the write edge. DATA/OUTSET/OUTCLR writes during a pulse update data_reg only; pulse_mask is unaffected.
- Read path:
  - readdata <= mux(address) every clock, regardless of chipselect; read latency is 1 clock.
  - DATA, OUT and PULSE return values zero-extended from WIDTH; PLEN returns a value zero-extended from PULSE_W.
  - A read in the same cycle as a write to the same register returns the old value.
- Reset (asynchronous, any time, including mid-pulse): data_reg = RESET_VALUE, plen = PULSE_DEFAULT, pulse_mask = 0, cnt = 0, state IDLE, readdata = 0, out_port = RESET_VALUE.

Decomposition:
- Shared package soc_system_pio_pkg holds:
  - register offset constants (ADDR_DATA=0, ADDR_OUT=2, ADDR_OUTSET=4, ADDR_OUTCLR=5, ADDR_PULSE=6, ADDR_PLEN=7);
  - the pulse state enum (PULSE_IDLE, PULSE_ACTIVE).
- One sub-module, soc_system_led_pio_pulse_timer. It contains the state, cnt and pulse_mask logic. Inputs: trigger, mask_in and plen. Output: pulse_mask.

Test Plan:
1. Reset release, WIDTH=4, RESET_VALUE=4'b0101 -> out_port=0101. A read of offset 7 returns 1000 one cycle after the address is presented.
2. Write DATA=0x3, then OUTSET=0x8, then OUTCLR=0x1 -> out_port goes 0011, 1011, 1010. A read of offset 0 returns 0x0000000A.
3. PLEN=5, DATA=0, PULSE=0x4 -> out_port[2]=1 for exactly 5 clocks, then 0. Offset 6 reads 0x4 during the pulse and 0x0 after.
4. PLEN=5, PULSE=0x1, then PULSE=0x2 three clocks later -> out_port=0011 for 5 clocks after the second write; bit0 is held for 8 clocks total.
5. PLEN=0 and PULSE=0xF, also PULSE=0 with PLEN=5 -> no change on out_port; state stays IDLE.
6. Assert reset_n low mid-pulse (cnt=3, DATA=0x6) -> out_port immediately equals RESET_VALUE. After release, no residual pulse remains and PLEN reads 1000.
